spi_rom_arbiter: RTL and testbench

Shared-access controller for the external SPI flash ROM in the VGA designs. Two requesters (port 0: scanline/display prefetch; port 1: auxiliary fetch, e.g. sprite or palette data) issue read requests of 1–16 bytes. The block arbitrates between them and runs the complete 03h READ transaction on the SPI pins. It returns received bytes tagged with the owning port.

---
 rtl/spi_rom_arbiter_if.sv | 28 ++
 rtl/spi_rom_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_rom_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rom_arbiter_if.sv
// Requester-side bus of the SPI flash ROM arbiter: two read request ports plus
// the shared read-data return path. The arbiter takes the slave modport.
interface spi_rom_arbiter_if;
    logic        req0;
    logic        req1;
    logic [23:0] addr0;
    logic [23:0] addr1;
    logic [3:0]  len0;
    logic [3:0]  len1;
    logic        gnt0;
    logic        gnt1;
    logic        abort;
    logic        busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_id;
    logic        rd_last;

    modport slave (
        input  req0, req1, addr0, addr1, len0, len1, abort,
        output gnt0, gnt1, busy, rd_data, rd_valid, rd_id, rd_last
    );

    modport master (
        output req0, req1, addr0, addr1, len0, len1, abort,
        input  gnt0, gnt1, busy, rd_data, rd_valid, rd_id, rd_last
    );
endinterface

// File: rtl/spi_rom_arbiter.sv
// Two-port arbiter running 03h READ transactions on an external SPI flash ROM.
// Define SPI_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module spi_rom_arbiter #(
    parameter int unsigned CS_GAP = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_rom_arbiter_if.slave   bus,
    output logic               spi_cs,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  logic               spi_miso
);
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned TX_W   = 32;
    localparam logic [7:0]        CMD_READ = 8'h03;
    localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_TURN, S_DATA, S_GAP
    } state_t;

    state_t             r_state;
    logic [TX_W-1:0]    r_tx;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_rx;
    logic [LEN_W-1:0]   r_len;
    logic               r_id;
    logic [GAP_W-1:0]   r_gap;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_busy;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic               r_rd_id;
    logic               r_rd_last;
    logic               r_cs;
    logic               r_mosi;

    logic               w_any_req;
    logic               w_pick1;
    logic [ADDR_W-1:0]  w_addr;
    logic [LEN_W-1:0]   w_len;
    logic [7:0]         w_rx_next;
    logic               w_byte_done;
    logic               w_last_byte;
    logic               w_in_txn;

    assign w_any_req   = bus.req0 | bus.req1;
    assign w_addr      = w_pick1 ? bus.addr1 : bus.addr0;
    assign w_len       = w_pick1 ? bus.len1  : bus.len0;
    assign w_rx_next   = {r_rx[6:0], spi_miso};
    assign w_byte_done = (r_cnt[2:0] == 3'd7);
    assign w_last_byte = (r_cnt[CNT_W-1:3] == r_len);
    assign w_in_txn    = (r_state == S_CMD) || (r_state == S_ADDR) ||
                         (r_state == S_TURN) || (r_state == S_DATA);

`ifdef SPI_ARB_RR_EN
    logic r_last_id;
    // Contested grant goes to the port that did not win last time.
    assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last_id);
`else
    assign w_pick1 = bus.req1 & ~bus.req0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tx       <= '0;
            r_cnt      <= '0;
            r_rx       <= '0;
            r_len      <= '0;
            r_id       <= 1'b0;
            r_gap      <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_id    <= 1'b0;
            r_rd_last  <= 1'b0;
            r_cs       <= 1'b0;
            r_mosi     <= 1'b0;
`ifdef SPI_ARB_RR_EN
            r_last_id  <= 1'b1;
`endif
        end else begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;

            case (r_state)
                // IDLE always has r_gap == 0, so it shares the grant path with an expired GAP.
                S_IDLE, S_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - GAP_W'(1);
                    end else if (w_any_req) begin
                        r_id    <= w_pick1;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_len   <= w_len;
                        r_tx    <= {CMD_READ[6:0], w_addr, 1'b0};
                        r_mosi  <= CMD_READ[7];
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_CMD;
`ifdef SPI_ARB_RR_EN
                        r_last_id <= w_pick1;
`endif
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CMD: begin
                    r_mosi <= r_tx[TX_W-1];
                    r_tx   <= {r_tx[TX_W-2:0], 1'b0};
                    if (r_cnt == CNT_W'(7)) begin
                        r_cnt   <= '0;
                        r_state <= S_ADDR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ADDR: begin
                    if (r_cnt == CNT_W'(23)) begin
                        r_mosi  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_TURN;
                    end else begin
                        r_mosi <= r_tx[TX_W-1];
                        r_tx   <= {r_tx[TX_W-2:0], 1'b0};
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                // The edge leaving TURN samples data bit 0; the ROM drove it during TURN.
                S_TURN, S_DATA: begin
                    r_rx    <= w_rx_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= S_DATA;
                    if (w_byte_done) begin
                        r_rd_data  <= w_rx_next;
                        r_rd_valid <= 1'b1;
                        r_rd_id    <= r_id;
                        r_rd_last  <= w_last_byte;
                        if (w_last_byte) begin
                            r_cs    <= 1'b0;
                            r_gap   <= GAP_INIT;
                            r_state <= S_GAP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Abort wins over the case above; a byte completing on this edge still goes out.
            if (bus.abort && w_in_txn) begin
                r_cs      <= 1'b0;
                r_mosi    <= 1'b0;
                r_rd_last <= 1'b0;
                r_gap     <= GAP_INIT;
                r_state   <= S_GAP;
            end
        end
    end

    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.busy     = r_busy;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_id    = r_rd_id;
    assign bus.rd_last  = r_rd_last;
    assign spi_cs       = r_cs;
    assign spi_mosi     = r_mosi;
    assign spi_sclk     = ~clk;
endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Scoreboard bench for spi_rom_arbiter: directed requests feed an expected-byte
// queue, a negedge monitor checks every rd_valid strobe; a ROM model serves data.
module tb_spi_rom_arbiter;
    localparam int unsigned CS_GAP = 2;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic spi_cs;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso = 1'b0;

    spi_rom_arbiter_if bus();

    spi_rom_arbiter #(.CS_GAP(CS_GAP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    exp_t        exp_q[$];
    int unsigned g_id[$];
    int unsigned g_cyc[$];
    int unsigned v_cyc[$];
    int unsigned cs_hi         = 0;
    int unsigned cs_fall_cyc   = 0;
    int unsigned busy_fall_cyc = 0;
    logic        cs_d   = 1'b0;
    logic        busy_d = 1'b0;

    logic [7:0]  rom_bytes [16];
    int unsigned rom_n   = 0;
    logic [31:0] rom_cmd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic id, input logic [7:0] data, input logic last);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic clear_log();
        g_id.delete();
        g_cyc.delete();
        v_cyc.delete();
        cs_hi         = 0;
        cs_fall_cyc   = 0;
        busy_fall_cyc = 0;
    endtask

    task automatic wait_gnt(input int port, output int unsigned gc);
        bit ok = 1'b0;
        gc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((port == 0 && bus.gnt0) || (port == 1 && bus.gnt1)) begin
                ok = 1'b1;
                gc = cyc;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_timeout port=%0d actual=none required=grant within 64 cycles", port);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus.busy && !spi_cs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout actual=busy required=idle within 400 cycles");
        end
        @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: shifts in command/address on sclk rise, then drives data MSB first.
    always @(negedge clk) begin
        if (spi_cs) begin
            if (rom_n < 32) begin
                rom_cmd = {rom_cmd[30:0], spi_mosi};
            end else begin
                int unsigned bi;
                int unsigned bb;
                bi = ((rom_n - 32) / 8) % 16;
                bb = 7 - ((rom_n - 32) % 8);
                spi_miso = rom_bytes[bi][bb];
            end
            rom_n++;
        end else begin
            rom_n    = 0;
            spi_miso = 1'b0;
        end
    end

    // Monitor: event log plus scoreboard comparison of every returned byte.
    always @(negedge clk) begin
        if (bus.gnt0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
        if (bus.gnt1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
        if (spi_cs) cs_hi++;
        if (cs_d && !spi_cs) cs_fall_cyc = cyc;
        if (busy_d && !bus.busy) busy_fall_cyc = cyc;
        cs_d   = spi_cs;
        busy_d = bus.busy;
        if (bus.rd_valid) begin
            v_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected actual id=%0d data=%02h last=%0b required=no strobe",
                         bus.rd_id, bus.rd_data, bus.rd_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_byte{id,data,last}", 32'({bus.rd_id, bus.rd_data, bus.rd_last}), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned g;
        int unsigned rc;
        int          cnt;
        int          bad;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        bus.len0 = '0;   bus.len1 = '0;
        bus.abort = 1'b0;
        for (int i = 0; i < 16; i++) rom_bytes[i] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({spi_cs, bus.busy, spi_mosi, bus.rd_valid, bus.gnt0, bus.gnt1}), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_outputs", 32'({spi_cs, bus.busy, bus.rd_valid, bus.gnt0, bus.gnt1}), 32'h0);

        // Single 1-byte read on port 0
        clear_log();
        rom_bytes[0] = 8'hA5;
        push_exp(1'b0, 8'hA5, 1'b1);
        bus.addr0 = 24'h000120; bus.len0 = 4'd0; bus.req0 = 1'b1;
        wait_gnt(0, g);
        bus.req0 = 1'b0;
        wait_idle();
        chk("t1_mosi_word", rom_cmd, 32'h03000120);
        chk("t1_valid_offset", (v_cyc.size() > 0) ? v_cyc[0] - g : 32'hFFFF, 40);
        chk("t1_cs_fall_offset", cs_fall_cyc - g, 40);
        chk("t1_cs_high_cycles", cs_hi, 40);
        chk("t1_busy_fall_offset", busy_fall_cyc - g, 40 + CS_GAP);

        // 16-byte read on port 1
        clear_log();
        for (int i = 0; i < 16; i++) begin
            rom_bytes[i] = 8'(i);
            push_exp(1'b1, 8'(i), (i == 15));
        end
        bus.addr1 = 24'h001000; bus.len1 = 4'd15; bus.req1 = 1'b1;
        wait_gnt(1, g);
        bus.req1 = 1'b0;
        wait_idle();
        chk("t2_mosi_word", rom_cmd, 32'h03001000);
        chk("t2_strobe_count", v_cyc.size(), 16);
        chk("t2_first_offset", (v_cyc.size() == 16) ? v_cyc[0] - g : 32'hFFFF, 40);
        chk("t2_last_offset", (v_cyc.size() == 16) ? v_cyc[15] - g : 32'hFFFF, 160);
        bad = 0;
        for (int i = 1; i < v_cyc.size(); i++) if (v_cyc[i] - v_cyc[i-1] != 8) bad++;
        chk("t2_bad_spacings", bad, 0);
        chk("t2_cs_high_cycles", cs_hi, 160);
        chk("t2_cs_fall_offset", cs_fall_cyc - g, 160);

        // Both ports requesting continuously
        clear_log();
        rom_bytes[0] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
`ifdef SPI_ARB_RR_EN
            push_exp(1'(i % 2), 8'h3C, 1'b1);
`else
            push_exp(1'b0, 8'h3C, 1'b1);
`endif
        end
        bus.addr0 = 24'h000200; bus.len0 = 4'd0;
        bus.addr1 = 24'h000300; bus.len1 = 4'd0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (g_id.size() >= 4) break;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();
        chk("t3_grant_count", g_id.size(), 4);
        if (g_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef SPI_ARB_RR_EN
                chk($sformatf("t3_grant%0d_port", i), g_id[i], i % 2);
`else
                chk($sformatf("t3_grant%0d_port", i), g_id[i], 0);
`endif
                if (i > 0) chk($sformatf("t3_grant%0d_spacing", i), g_cyc[i] - g_cyc[i-1], 40 + CS_GAP);
            end
        end

        // Abort after the second byte of a 4-byte read
        clear_log();
        rom_bytes[0] = 8'h11; rom_bytes[1] = 8'h22; rom_bytes[2] = 8'h33; rom_bytes[3] = 8'h44;
        push_exp(1'b0, 8'h11, 1'b0);
        push_exp(1'b0, 8'h22, 1'b0);
        bus.addr0 = 24'h000400; bus.len0 = 4'd3; bus.req0 = 1'b1;
        wait_gnt(0, g);
        bus.req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.rd_valid) cnt++;
            if (cnt == 2) break;
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_idle();
        chk("t4_cs_fall_offset", cs_fall_cyc - g, 49);
        chk("t4_busy_fall_offset", busy_fall_cyc - g, 49 + CS_GAP);
        chk("t4_strobe_count", v_cyc.size(), 2);

        // Asynchronous reset mid-address, then a fresh request
        clear_log();
        bus.addr0 = 24'hFFFFFF; bus.len0 = 4'd0; bus.req0 = 1'b1;
        wait_gnt(0, g);
        bus.req0 = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_pre_reset_cs_busy_mosi", 32'({spi_cs, bus.busy, spi_mosi}), 32'h7);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_reset_outputs", 32'({spi_cs, bus.busy, spi_mosi, bus.rd_valid}), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        rom_bytes[0] = 8'h5A;
        push_exp(1'b0, 8'h5A, 1'b1);
        bus.addr0 = 24'h00ABCD; bus.len0 = 4'd0; bus.req0 = 1'b1;
        rc = cyc;
        wait_gnt(0, g);
        bus.req0 = 1'b0;
        chk("t5_grant_latency", g - rc, 1);
        wait_idle();
        chk("t5_mosi_word", rom_cmd, 32'h0300ABCD);
        chk("t5_cs_high_cycles", cs_hi, 40);

        // Port 1 withdraws its request during a port 0 transaction
        clear_log();
        rom_bytes[0] = 8'h77; rom_bytes[1] = 8'h88;
        push_exp(1'b0, 8'h77, 1'b0);
        push_exp(1'b0, 8'h88, 1'b1);
        bus.addr0 = 24'h000600; bus.len0 = 4'd1; bus.req0 = 1'b1;
        wait_gnt(0, g);
        bus.req0 = 1'b0;
        repeat (5) @(negedge clk);
        bus.addr1 = 24'h000700; bus.len1 = 4'd0; bus.req1 = 1'b1;
        repeat (10) @(negedge clk);
        bus.req1 = 1'b0;
        wait_idle();
        repeat (60) @(negedge clk);
        chk("t6_grant_count", g_id.size(), 1);
        chk("t6_cs_high_cycles", cs_hi, 48);

        chk("scoreboard_remaining", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
